// File: rtl/span_painter_pkg.sv
// Shared opcodes, FSM encoding and command-word field positions for span_painter.
package span_painter_pkg;

    localparam logic [1:0] OP_SPAN  = 2'b00;
    localparam logic [1:0] OP_RECT  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_SWAP  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_FETCH2, S_WAIT2, S_PAINT, S_SWAP
    } state_t;

    typedef enum logic [1:0] {
        REJ_NONE, REJ_ORDER, REJ_XRANGE, REJ_YRANGE
    } reject_t;

    // Positions are relative to the bottom of the used field block; the block
    // itself sits at the top of the command word (op at the MSBs).
    function automatic int field_w(int x_w, int y_w, int color_w);
        return 2 + color_w + y_w + 2 * x_w;
    endfunction

    function automatic int xl_lsb(int x_w);
        return x_w;
    endfunction

    function automatic int y_lsb(int x_w);
        return 2 * x_w;
    endfunction

    function automatic int color_lsb(int x_w, int y_w);
        return 2 * x_w + y_w;
    endfunction

    function automatic int op_lsb(int x_w, int y_w, int color_w);
        return 2 * x_w + y_w + color_w;
    endfunction

endpackage

// File: rtl/span_cmd_decode.sv
// Splits a latched command into its fields and range-checks span/rect geometry.
module span_cmd_decode import span_painter_pkg::*; #(
    parameter int H_RES   = 160,
    parameter int V_RES   = 120,
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int COLOR_W = 3,
    parameter int FIELD_W = field_w(X_W, Y_W, COLOR_W)
) (
    input  logic [FIELD_W-1:0] cmd,
    output logic [1:0]         op,
    output logic [COLOR_W-1:0] color,
    output logic [Y_W-1:0]     y,
    output logic [X_W-1:0]     xl,
    output logic [X_W-1:0]     xr,
    output reject_t            reason
);
    localparam int XL_LSB = xl_lsb(X_W);
    localparam int Y_LSB  = y_lsb(X_W);
    localparam int C_LSB  = color_lsb(X_W, Y_W);
    localparam int OP_LSB = op_lsb(X_W, Y_W, COLOR_W);

    localparam logic [X_W:0] H_LIM = (X_W+1)'(H_RES);
    localparam logic [Y_W:0] V_LIM = (Y_W+1)'(V_RES);

    assign op    = cmd[OP_LSB +: 2];
    assign color = cmd[C_LSB +: COLOR_W];
    assign y     = cmd[Y_LSB +: Y_W];
    assign xl    = cmd[XL_LSB +: X_W];
    assign xr    = cmd[0 +: X_W];

    // Only meaningful for SPAN/RECT; the caller ignores it for CLEAR/SWAP.
    always_comb begin
        reason = REJ_NONE;
        if (xl > xr)
            reason = REJ_ORDER;
        else if ({1'b0, xr} >= H_LIM)
            reason = REJ_XRANGE;
        else if ({1'b0, y} >= V_LIM)
            reason = REJ_YRANGE;
    end

endmodule

// File: rtl/span_painter.sv
// Command-driven rasteriser: pops span/rect/clear/swap words from the PRAM FIFO
// and emits one frame-buffer write per cycle the frame buffer accepts.
module span_painter import span_painter_pkg::*; #(
    parameter int H_RES   = 160,
    parameter int V_RES   = 120,
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int COLOR_W = 3,
    parameter int ADDR_W  = 15,
    parameter int CMD_W   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               empty,
    input  logic [CMD_W-1:0]   PRAMdata,
    input  logic               swapBuffers,
    input  logic               fb_ready,
    output logic               re,
    output logic [ADDR_W-1:0]  addr,
    output logic [COLOR_W-1:0] data,
    output logic               we,
    output logic               swapBuffersCommand,
    output logic               busy,
    output logic               err
);
    localparam int FIELD_W = field_w(X_W, Y_W, COLOR_W);
    localparam logic [Y_W:0] V_LIM = (Y_W+1)'(V_RES);

    state_t             state, state_nx;
    logic [FIELD_W-1:0] cmd;
    logic [X_W-1:0]     x, xl, xr;
    logic [Y_W-1:0]     y, y_bot;
    logic [COLOR_W-1:0] color;
    logic [ADDR_W-1:0]  row_base;
    logic               err_r;

    logic [1:0]         d_op;
    logic [COLOR_W-1:0] d_color;
    logic [Y_W-1:0]     d_y;
    logic [X_W-1:0]     d_xl, d_xr;
    reject_t            d_reason;

    logic [Y_W-1:0]     pd_ybot;
    logic               rej, ybot_bad, x_end, y_end;

    span_cmd_decode #(
        .H_RES(H_RES), .V_RES(V_RES), .X_W(X_W), .Y_W(Y_W),
        .COLOR_W(COLOR_W), .FIELD_W(FIELD_W)
    ) u_dec (
        .cmd(cmd), .op(d_op), .color(d_color), .y(d_y),
        .xl(d_xl), .xr(d_xr), .reason(d_reason)
    );

    assign pd_ybot  = PRAMdata[Y_W-1:0];
    assign rej      = (d_reason != REJ_NONE);
    assign ybot_bad = (pd_ybot < y) || ({1'b0, pd_ybot} >= V_LIM);
    assign x_end    = (x == xr);
    assign y_end    = (y == y_bot);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (!empty) state_nx = S_FETCH;
            S_FETCH:  state_nx = S_WAIT;
            S_WAIT:   state_nx = S_DECODE;
            S_DECODE: begin
                case (d_op)
                    OP_SPAN:  state_nx = rej ? S_IDLE : S_PAINT;
                    OP_RECT:  state_nx = rej ? S_IDLE : S_FETCH2;
                    OP_CLEAR: state_nx = S_PAINT;
                    default:  state_nx = S_SWAP;
                endcase
            end
            S_FETCH2: if (!empty) state_nx = S_WAIT2;
            S_WAIT2:  state_nx = ybot_bad ? S_IDLE : S_PAINT;
            S_PAINT:  if (fb_ready && x_end && y_end) state_nx = S_IDLE;
            S_SWAP:   if (swapBuffers) state_nx = S_SWAP == state ? S_IDLE : state;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Row base is multiplied once per command; subsequent rows just add H_RES.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd      <= '0;
            x        <= '0;
            xl       <= '0;
            xr       <= '0;
            y        <= '0;
            y_bot    <= '0;
            color    <= '0;
            row_base <= '0;
            err_r    <= 1'b0;
        end else begin
            case (state)
                S_WAIT: cmd <= PRAMdata[CMD_W-1 -: FIELD_W];
                S_DECODE: begin
                    color <= d_color;
                    if (d_op == OP_CLEAR) begin
                        row_base <= '0;
                        x        <= '0;
                        xl       <= '0;
                        xr       <= X_W'(H_RES - 1);
                        y        <= '0;
                        y_bot    <= Y_W'(V_RES - 1);
                    end else if (d_op != OP_SWAP) begin
                        if (rej) begin
                            err_r <= 1'b1;
                        end else begin
                            row_base <= ADDR_W'(d_y) * ADDR_W'(H_RES);
                            x        <= d_xl;
                            xl       <= d_xl;
                            xr       <= d_xr;
                            y        <= d_y;
                            y_bot    <= d_y;
                        end
                    end
                end
                S_WAIT2: begin
                    if (ybot_bad) err_r <= 1'b1;
                    else          y_bot <= pd_ybot;
                end
                S_PAINT: begin
                    if (fb_ready) begin
                        if (!x_end) begin
                            x <= x + 1'b1;
                        end else if (!y_end) begin
                            x        <= xl;
                            y        <= y + 1'b1;
                            row_base <= row_base + ADDR_W'(H_RES);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign re                 = (state == S_FETCH) || (state == S_FETCH2 && !empty);
    assign we                 = (state == S_PAINT);
    assign addr               = row_base + ADDR_W'(x);
    assign data               = color;
    assign swapBuffersCommand = (state == S_SWAP);
    assign busy               = (state != S_IDLE);
    assign err                = err_r;

endmodule

// File: tb/tb_span_painter.sv
// Directed + randomized bench for span_painter against a pixel-list reference model.
module tb_span_painter;
    localparam int H = 160;
    localparam int V = 120;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        empty = 1'b1;
    logic        swapBuffers = 1'b0;
    logic        fb_ready = 1'b1;
    logic [31:0] pram = '0;
    logic        re, we, swapBuffersCommand, busy, err;
    logic [14:0] addr;
    logic [2:0]  data;

    span_painter dut (
        .clk(clk), .reset(reset), .empty(empty), .PRAMdata(pram),
        .swapBuffers(swapBuffers), .fb_ready(fb_ready), .re(re), .addr(addr),
        .data(data), .we(we), .swapBuffersCommand(swapBuffersCommand),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [14:0] a; logic [2:0] d;} px_t;

    logic [31:0] q[$];
    logic [31:0] mq[$];
    px_t         exp_q[$];
    bit          exp_err = 1'b0;
    int          checks = 0, errors = 0, nwrites = 0, ready_mode = 0;
    bit          held_valid = 1'b0;
    logic [14:0] held_a;
    logic [2:0]  held_d;

    // FIFO: word appears on pram the cycle after the pop strobe.
    always @(posedge clk) begin
        if (re && q.size() != 0) pram <= q.pop_front();
        empty <= (q.size() == 0);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv)
        else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    function automatic logic [31:0] mk(int op, int col, int y, int xl, int xr);
        logic [3:0] lo;
        lo = 4'($urandom);
        return {op[1:0], col[2:0], y[6:0], xl[7:0], xr[7:0], lo};
    endfunction

    function automatic logic [31:0] ybw(int yb, bit swap_top);
        logic [24:0] hi;
        hi = 25'($urandom);
        if (swap_top) hi[24:23] = 2'b11;
        else          hi[24:23] = 2'b00;
        return {hi, yb[6:0]};
    endfunction

    task automatic push(input logic [31:0] w);
        q.push_back(w);
        mq.push_back(w);
    endtask

    task automatic paint(input int y0, input int y1, input int x0, input int x1, input int col);
        for (int yy = y0; yy <= y1; yy++)
            for (int xx = x0; xx <= x1; xx++)
                exp_q.push_back({15'(yy * H + xx), 3'(col)});
    endtask

    // Consumes the command stream the same order the FIFO delivers it.
    task automatic model_drain();
        logic [31:0] w, w2;
        int op, col, y, xl, xr, yb;
        while (mq.size() != 0) begin
            w  = mq.pop_front();
            op = int'(w[31:30]); col = int'(w[29:27]); y = int'(w[26:20]);
            xl = int'(w[19:12]); xr = int'(w[11:4]);
            if (op == 2) begin
                paint(0, V - 1, 0, H - 1, col);
            end else if (op < 2) begin
                if (xl > xr || xr >= H || y >= V) begin
                    exp_err = 1'b1;
                end else if (op == 0) begin
                    paint(y, y, xl, xr, col);
                end else begin
                    w2 = mq.pop_front();
                    yb = int'(w2[6:0]);
                    if (yb < y || yb >= V) exp_err = 1'b1;
                    else                   paint(y, yb, xl, xr, col);
                end
            end
        end
    endtask

    task automatic tick();
        px_t e;
        @(negedge clk);
        case (ready_mode)
            0:       fb_ready = 1'b1;
            1:       fb_ready = ~fb_ready;
            default: fb_ready = ($urandom_range(0, 3) != 0);
        endcase
        #1;
        if (held_valid) begin
            chk("stall_we", 32'(we), 1);
            chk("stall_addr", 32'(addr), 32'(held_a));
            chk("stall_data", 32'(data), 32'(held_d));
        end
        held_valid = 1'b0;
        if (we === 1'b1) begin
            if (fb_ready) begin
                nwrites++;
                chk("write_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(addr), 32'(e.a));
                    chk("wr_data", 32'(data), 32'(e.d));
                end
            end else begin
                held_valid = 1'b1;
                held_a = addr;
                held_d = data;
            end
        end
    endtask

    task automatic run(input int bound, output int first_w);
        int n;
        bit done;
        n = 0; done = 1'b0; first_w = -1;
        while (!done && n < bound) begin
            tick();
            n++;
            if (first_w < 0 && we === 1'b1) first_w = n;
            if (q.size() == 0 && empty === 1'b1 && busy === 1'b0 && exp_q.size() == 0) done = 1'b1;
        end
        chk("run_done", 32'(done), 1);
    endtask

    initial begin
        int fw, base, n, op, col, y, xl, xr, yb;
        bit seen;

        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_re", 32'(re), 0);
        chk("rst_we", 32'(we), 0);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_data", 32'(data), 0);
        chk("rst_swapcmd", 32'(swapBuffersCommand), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        reset = 1'b1;
        repeat (2) tick();

        // single span: 330..333, first write three cycles after the IDLE pop decision
        push(mk(0, 5, 2, 10, 13)); model_drain();
        run(100, fw);
        chk("span_latency", 32'(fw), 5);
        chk("span_err", 32'(err), 0);

        // rect at the right edge: 158,159,318,319
        push(mk(1, 3, 0, 158, 159)); push(ybw(1, 1'b0)); model_drain();
        run(100, fw);
        chk("rect_err", 32'(err), 0);

        // rejects, then a valid single pixel at the very last frame address
        push(mk(0, 2, 4, 20, 5)); model_drain(); run(50, fw);
        chk("err_order", 32'(err), 32'(exp_err));
        push(mk(0, 2, 120, 0, 3)); model_drain(); run(50, fw);
        chk("err_yrange", 32'(err), 32'(exp_err));
        push(mk(0, 2, 3, 160, 160)); model_drain(); run(50, fw);
        chk("err_xrange", 32'(err), 32'(exp_err));
        base = nwrites;
        push(mk(0, 7, 119, 159, 159)); model_drain(); run(50, fw);
        chk("last_px_count", 32'(nwrites - base), 1);
        chk("err_sticky", 32'(err), 1);

        // swap handshake with a span queued behind it
        push(mk(3, 0, 0, 0, 0)); push(mk(0, 4, 7, 1, 3)); model_drain();
        seen = 1'b0; n = 0;
        while (!seen && n < 20) begin
            tick(); n++;
            if (swapBuffersCommand === 1'b1) seen = 1'b1;
        end
        chk("swap_entered", 32'(seen), 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("swap_hold", 32'(swapBuffersCommand), 1);
            chk("swap_no_pop", 32'(re), 0);
        end
        swapBuffers = 1'b1;
        tick();
        chk("swap_cleared", 32'(swapBuffersCommand), 0);
        tick();
        chk("swap_next_pop", 32'(re), 1);
        swapBuffers = 1'b0;
        run(100, fw);

        // full clear under a 50% write-acceptance pattern
        ready_mode = 1;
        base = nwrites;
        push(mk(2, 0, 0, 0, 0)); model_drain();
        run(45000, fw);
        chk("clear_count", 32'(nwrites - base), H * V);

        // randomized span/rect/swap mix
        ready_mode = 2;
        swapBuffers = 1'b1;
        for (int i = 0; i < 40; i++) begin
            op  = $urandom_range(0, 9);
            col = $urandom_range(0, 7);
            y   = ($urandom_range(0, 9) == 0) ? $urandom_range(120, 127) : $urandom_range(0, 119);
            xl  = $urandom_range(0, 159);
            xr  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : xl + $urandom_range(0, 12);
            if (op < 5) begin
                push(mk(0, col, y, xl, xr));
            end else if (op < 9) begin
                yb = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 127) : y + $urandom_range(0, 3);
                push(mk(1, col, y, xl, xr));
                push(ybw(yb, 1'b1));
            end else begin
                push(mk(3, col, y, xl, xr));
            end
            model_drain();
            run(5000, fw);
            chk("rand_err", 32'(err), 32'(exp_err));
        end

        // reset in the middle of a rect abandons it; the next word starts fresh
        ready_mode = 0;
        swapBuffers = 1'b0;
        push(mk(1, 6, 10, 0, 9)); push(ybw(12, 1'b0)); model_drain();
        q.push_back(mk(0, 1, 50, 30, 33));
        base = nwrites; n = 0;
        while (nwrites - base < 3 && n < 50) begin
            tick(); n++;
        end
        chk("mid_rect_reached", 32'(nwrites - base), 3);
        reset = 1'b0;
        #1;
        chk("mid_rst_we", 32'(we), 0);
        chk("mid_rst_re", 32'(re), 0);
        chk("mid_rst_addr", 32'(addr), 0);
        chk("mid_rst_data", 32'(data), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_err", 32'(err), 0);
        exp_q.delete();
        exp_err = 1'b0;
        held_valid = 1'b0;
        mq.push_back(mk(0, 1, 50, 30, 33));
        mq[0] = q[0];
        model_drain();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        run(200, fw);
        chk("post_rst_err", 32'(err), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
